// File: rtl/blk_stage3_pkg.sv
// ---------------------------------------------------------------------------
// blk_stage3_pkg
// Shared types and constants for the blk_stage3 serial-capture stage.
//   blk_stage3_state_t   : capture FSM states (IDLE, SHIFT, PAR, HOLD)
//   BLK_STAGE3_WIDTH_DEF : default number of data bits per frame
// ---------------------------------------------------------------------------
package blk_stage3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    PAR   = 2'd2,
    HOLD  = 2'd3
  } blk_stage3_state_t;

  localparam int BLK_STAGE3_WIDTH_DEF = 8;

endpackage

// File: rtl/blk_stage3_shreg.sv
// ---------------------------------------------------------------------------
// blk_stage3_shreg
// WIDTH-bit indexed-load shift register with bit counter. Each shift writes
// i_bit at the position given by the counter, so bit 0 is the first bit
// received (LSB first).
// Ports:
//   clk          : clock, rising edge
//   rst_n        : synchronous active-low reset
//   i_clear      : start of frame, counter back to 0
//   i_shift      : load i_bit at the current index, advance counter
//   i_bit        : serial data bit
//   o_word       : registered word assembled so far
//   o_wordNext   : o_word with i_bit merged at the current index
//   o_last       : counter points at bit WIDTH-1
// ---------------------------------------------------------------------------
module blk_stage3_shreg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_shift,
  input  logic             i_bit,
  output logic [WIDTH-1:0] o_word,
  output logic [WIDTH-1:0] o_wordNext,
  output logic             o_last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_word;

  // Counter saturates at WIDTH-1 instead of wrapping; the next start bit
  // brings it back to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_word <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_shift) begin
      r_word[r_cnt] <= i_bit;
      if (r_cnt != LAST_IDX) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // The top loads the output word on the same edge that samples the last
  // bit, so it needs the word including the bit being sampled right now.
  always_comb begin
    o_wordNext        = r_word;
    o_wordNext[r_cnt] = i_bit;
  end

  assign o_word = r_word;
  assign o_last = (r_cnt == LAST_IDX);

endmodule

// File: rtl/blk_stage3.sv
// ---------------------------------------------------------------------------
// blk_stage3
// Serial-capture stage: detects a start bit on in1, shifts in WIDTH data
// bits LSB first, optionally checks an even-parity bit, and holds the word
// on a valid/ready interface. Line activity while a word is unaccepted is
// dropped and flagged in the sticky ovr flag.
// Optional feature macro: BLK_STAGE3_PARITY_EN (adds PAR state and perr).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset
//   in1    : serial line, idles at 0
//   ready  : downstream accepts data when high together with valid
//   data   : captured word, bit 0 = first data bit received
//   valid  : data/perr hold a word not yet accepted
//   perr   : parity error of the word in data (0 without parity)
//   ovr    : sticky overrun flag, cleared only by reset
// ---------------------------------------------------------------------------
module blk_stage3
  import blk_stage3_pkg::*;
#(
  parameter int WIDTH = BLK_STAGE3_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in1,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             perr,
  output logic             ovr
);

  blk_stage3_state_t r_state;
  logic [WIDTH-1:0]  r_data;
  logic              r_valid;
  logic              r_ovr;

  logic              w_clear;
  logic              w_shift;
  logic              w_last;
  logic [WIDTH-1:0]  w_word;
  logic [WIDTH-1:0]  w_wordNext;

`ifdef BLK_STAGE3_PARITY_EN
  logic              r_perr;
`endif

  // A start bit is seen in IDLE, and also on a handshake edge in HOLD so
  // back-to-back frames need no idle cycle.
  assign w_clear = in1 && ((r_state == IDLE) || ((r_state == HOLD) && ready));
  assign w_shift = (r_state == SHIFT);

  blk_stage3_shreg #(
    .WIDTH(WIDTH)
  ) u_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_clear   (w_clear),
    .i_shift   (w_shift),
    .i_bit     (in1),
    .o_word    (w_word),
    .o_wordNext(w_wordNext),
    .o_last    (w_last)
  );

  // Capture FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ovr   <= 1'b0;
`ifdef BLK_STAGE3_PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (in1) begin
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          if (w_last) begin
`ifdef BLK_STAGE3_PARITY_EN
            r_state <= PAR;
`else
            r_data  <= w_wordNext;
            r_valid <= 1'b1;
            r_state <= HOLD;
`endif
          end
        end
`ifdef BLK_STAGE3_PARITY_EN
        PAR: begin
          // Even parity over data bits plus parity bit: nonzero XOR is an error.
          r_data  <= w_word;
          r_perr  <= (^w_word) ^ in1;
          r_valid <= 1'b1;
          r_state <= HOLD;
        end
`endif
        HOLD: begin
          if (ready) begin
            r_valid <= 1'b0;
            r_state <= in1 ? SHIFT : IDLE;
          end else if (in1) begin
            r_ovr <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign data  = r_data;
  assign valid = r_valid;
  assign ovr   = r_ovr;
`ifdef BLK_STAGE3_PARITY_EN
  assign perr  = r_perr;
`else
  assign perr  = 1'b0;
`endif

endmodule

// File: tb/tb_blk_stage3.sv
// ---------------------------------------------------------------------------
// tb_blk_stage3
// Bench for blk_stage3: an 8-bit instance driven through a scoreboard queue
// and a 2-bit instance for the narrow-width boundary.
// Optional feature macro: BLK_STAGE3_PARITY_EN.
// ---------------------------------------------------------------------------
module tb_blk_stage3;

  logic       clk;
  logic       rst_n;

  logic       in1;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       perr;
  logic       ovr;

  logic       inB;
  logic       readyB;
  logic [1:0] dataB;
  logic       validB;
  logic       perrB;
  logic       ovrB;

  int compared   = 0;
  int mismatched = 0;

  logic [8:0] sbQ[$];

  blk_stage3 #(.WIDTH(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in1  (in1),
    .ready(ready),
    .data (data),
    .valid(valid),
    .perr (perr),
    .ovr  (ovr)
  );

  blk_stage3 #(.WIDTH(2)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .in1  (inB),
    .ready(readyB),
    .data (dataB),
    .valid(validB),
    .perr (perrB),
    .ovr  (ovrB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame on the 8-bit instance and pushes its expected word.
  // With chkTiming, valid must be low just before the final sampling edge
  // and high right after it.
  task automatic applyStimulus(input logic [7:0] w, input bit parBit, input bit chkTiming);
    logic [8:0] e;
`ifdef BLK_STAGE3_PARITY_EN
    e = {(^w) ^ parBit, w};
`else
    e = {1'b0, w};
`endif
    sbQ.push_back(e);
    in1 = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      in1 = w[i];
`ifndef BLK_STAGE3_PARITY_EN
      if (i == 7 && chkTiming) checkOutput("validPreLast", {31'd0, valid}, 32'd0);
`endif
      tick();
    end
`ifdef BLK_STAGE3_PARITY_EN
    in1 = parBit;
    if (chkTiming) checkOutput("validPreLast", {31'd0, valid}, 32'd0);
    tick();
`endif
    in1 = 1'b0;
    if (chkTiming) checkOutput("validRise", {31'd0, valid}, 32'd1);
  endtask

  // Drives one frame on the 2-bit instance (correct parity when enabled),
  // holding readyB low so the word can be inspected.
  task automatic sendNarrow(input logic [1:0] w);
    readyB = 1'b0;
    inB = 1'b1;
    tick();
    inB = w[0];
    tick();
    checkOutput("w2ValidEarly", {31'd0, validB}, 32'd0);
    inB = w[1];
    tick();
`ifdef BLK_STAGE3_PARITY_EN
    checkOutput("w2ValidPrePar", {31'd0, validB}, 32'd0);
    inB = ^w;
    tick();
`endif
    inB = 1'b0;
    checkOutput("w2Valid", {31'd0, validB}, 32'd1);
    checkOutput("w2Data", {30'd0, dataB}, {30'd0, w});
    checkOutput("w2Perr", {31'd0, perrB}, 32'd0);
    readyB = 1'b1;
    tick();
    readyB = 1'b0;
    checkOutput("w2ValidDrop", {31'd0, validB}, 32'd0);
  endtask

  // Scoreboard monitor: a word is consumed when valid and ready are both
  // high going into the next rising edge.
  always @(negedge clk) begin
    if (rst_n && valid && ready) begin
      if (sbQ.size() == 0) begin
        checkOutput("sbUnexpected", 32'd1, 32'd0);
      end else begin
        logic [8:0] e;
        e = sbQ.pop_front();
        checkOutput("sbData", {24'd0, data}, {24'd0, e[7:0]});
        checkOutput("sbPerr", {31'd0, perr}, {31'd0, e[8]});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    mismatched++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    rst_n  = 1'b0;
    in1    = 1'b0;
    ready  = 1'b1;
    inB    = 1'b0;
    readyB = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checkOutput("rstData", {24'd0, data}, 32'd0);
    checkOutput("rstValid", {31'd0, valid}, 32'd0);
    checkOutput("rstPerr", {31'd0, perr}, 32'd0);
    checkOutput("rstOvr", {31'd0, ovr}, 32'd0);

    // Reset mid-frame: start bit plus 3 data bits, then reset.
    $display("[TB] reset mid-frame");
    in1 = 1'b1; tick();
    in1 = 1'b1; tick();
    in1 = 1'b0; tick();
    in1 = 1'b1; tick();
    rst_n = 1'b0;
    in1 = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midRstValid", {31'd0, valid}, 32'd0);
    checkOutput("midRstData", {24'd0, data}, 32'd0);
    checkOutput("midRstOvr", {31'd0, ovr}, 32'd0);
    tick();
    tick();
    checkOutput("idleValid", {31'd0, valid}, 32'd0);
    applyStimulus(8'hA5, 1'b0, 1'b1);

    // Single frame, valid drops one edge after it rises (ready high).
    $display("[TB] single frame");
    tick();
    checkOutput("validDrop", {31'd0, valid}, 32'd0);
    tick();
    applyStimulus(8'hA5, 1'b0, 1'b1);
    checkOutput("singleData", {24'd0, data}, 32'h0000_00A5);

    // Back-to-back: second start bit lands on the handshake edge.
    $display("[TB] back-to-back");
    applyStimulus(8'h3C, 1'b0, 1'b1);
    applyStimulus(8'hC3, 1'b0, 1'b1);
    checkOutput("b2bOvr", {31'd0, ovr}, 32'd0);
    tick();
    checkOutput("b2bValidDrop", {31'd0, valid}, 32'd0);

    // Randomised frames.
    $display("[TB] random frames");
    for (int k = 0; k < 4; k++) begin
      logic [7:0] rw;
      rw = 8'($urandom_range(0, 255));
      applyStimulus(rw, ^rw, 1'b1);
      if (k[0]) tick();
    end
    tick();

    // Backpressure: word held while the line toggles -> overrun.
    $display("[TB] backpressure");
    ready = 1'b0;
    applyStimulus(8'h0F, 1'b0, 1'b1);
    in1 = 1'b1; tick();
    in1 = 1'b1; tick();
    in1 = 1'b0;
    checkOutput("bpData", {24'd0, data}, 32'h0000_000F);
    checkOutput("bpValid", {31'd0, valid}, 32'd1);
    checkOutput("bpOvr", {31'd0, ovr}, 32'd1);
    ready = 1'b1;
    tick();
    checkOutput("bpValidDrop", {31'd0, valid}, 32'd0);
    checkOutput("bpOvrSticky", {31'd0, ovr}, 32'd1);
    checkOutput("bpDataKept", {24'd0, data}, 32'h0000_000F);
    tick();

`ifdef BLK_STAGE3_PARITY_EN
    // Parity: correct and wrong parity bit for word 0x01.
    $display("[TB] parity");
    applyStimulus(8'h01, 1'b1, 1'b1);
    tick();
    applyStimulus(8'h01, 1'b0, 1'b1);
    tick();
`endif

    // Narrow instance: two frames, counter restarts from 0 each time.
    $display("[TB] WIDTH=2 boundary");
    sendNarrow(2'b11);
    tick();
    sendNarrow(2'b01);
    checkOutput("w2Ovr", {31'd0, ovrB}, 32'd0);

    tick();
    tick();
    checkOutput("sbEmpty", sbQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
